// File: rtl/fft_pkg.sv
// Shared constants and FSM state encoding for the radix-4 FFT stage sequencer.
// Default geometry is a 16-point transform; blocks may override FFT_SIZE locally.
package fft_pkg;

    localparam int unsigned FFT_SIZE = 16;
    localparam int unsigned ADDR_W   = $clog2(FFT_SIZE);
    localparam int unsigned STAGES   = ADDR_W / 2;

    typedef logic [1:0] fsm_state_t;

    localparam fsm_state_t StIdle  = 2'd0;
    localparam fsm_state_t StIssue = 2'd1;
    localparam fsm_state_t StDrain = 2'd2;
    localparam fsm_state_t StDone  = 2'd3;

    // Width of a counter able to hold 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fft4_addr_gen.sv
// Combinational radix-4 DIF address generator: (stage, butterfly, operand) to
// data-memory and twiddle ROM addresses. Shared by the read and write-back paths.
module fft4_addr_gen #(
    parameter int unsigned FFT_SIZE = fft_pkg::FFT_SIZE,
    parameter int unsigned ADDR_W   = $clog2(FFT_SIZE),
    parameter int unsigned STAGE_W  = fft_pkg::cnt_width($clog2(FFT_SIZE) / 2)
) (
    input  logic [STAGE_W-1:0] stage,
    input  logic [ADDR_W-3:0]  bfly,
    input  logic [1:0]         q,
    output logic [ADDR_W-1:0]  data_addr,
    output logic [ADDR_W-1:0]  tw_addr
);

    int unsigned       span_log2;
    logic [ADDR_W-1:0] bfly_ext;
    logic [ADDR_W-1:0] span_mask;
    logic [ADDR_W-1:0] j_idx;
    logic [ADDR_W-1:0] group_base;
    logic [ADDR_W-1:0] q_offset;

    always_comb begin
        // span = FFT_SIZE >> 2(s+1) is a power of 4, so divide/modulo become shift/mask.
        span_log2  = ADDR_W - 2 * (32'(stage) + 1);
        bfly_ext   = {2'b00, bfly};
        span_mask  = (ADDR_W'(1) << span_log2) - ADDR_W'(1);
        j_idx      = bfly_ext & span_mask;
        group_base = (bfly_ext >> span_log2) << (span_log2 + 2);
        q_offset   = ADDR_W'(q) << span_log2;
        data_addr  = group_base | j_idx | q_offset;
        // Truncation to ADDR_W bits is the modulo-FFT_SIZE wrap of the twiddle index.
        tw_addr    = (ADDR_W'(q) * j_idx) << (2 * 32'(stage));
    end

endmodule

// File: rtl/fft4_stage_sequencer.sv
// Sequences an in-place radix-4 DIF FFT: streams registered operand beats (data and
// twiddle addresses) to the butterfly datapath stage by stage, with a drain handshake.
module fft4_stage_sequencer #(
    parameter int unsigned FFT_SIZE = fft_pkg::FFT_SIZE,
    parameter int unsigned ADDR_W   = $clog2(FFT_SIZE),
    parameter int unsigned STAGES   = $clog2(FFT_SIZE) / 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [ADDR_W-1:0] op_data_addr,
    output logic [ADDR_W-1:0] op_tw_addr,
    output logic [1:0]        op_q,
    output logic              op_last_bfly,
    output logic              op_last_stage,
    input  logic              stage_drained
);

    import fft_pkg::*;

    localparam int unsigned STAGE_W = cnt_width(STAGES);
    localparam int unsigned BFLY_W  = ADDR_W - 2;

    localparam logic [BFLY_W-1:0]  LAST_BFLY  = BFLY_W'(FFT_SIZE / 4 - 1);
    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(STAGES - 1);

    fsm_state_t         state_q, state_d;
    logic [STAGE_W-1:0] stage_q, stage_d;
    logic [BFLY_W-1:0]  bfly_q, bfly_d;
    logic [1:0]         q_q, q_d;
    logic               handshake;
    logic [ADDR_W-1:0]  gen_data_addr;
    logic [ADDR_W-1:0]  gen_tw_addr;

    assign handshake = op_valid & op_ready;

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        bfly_d  = bfly_q;
        q_d     = q_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StIssue;
                    stage_d = '0;
                    bfly_d  = '0;
                    q_d     = '0;
                end
            end
            StIssue: begin
                if (handshake) begin
                    q_d = q_q + 2'd1;
                    if (q_q == 2'd3) begin
                        if (bfly_q == LAST_BFLY) begin
                            state_d = StDrain;
                            bfly_d  = '0;
                        end else begin
                            bfly_d = bfly_q + BFLY_W'(1);
                        end
                    end
                end
            end
            StDrain: begin
                if (stage_drained) begin
                    if (stage_q == LAST_STAGE) begin
                        state_d = StDone;
                    end else begin
                        state_d = StIssue;
                        stage_d = stage_q + STAGE_W'(1);
                        bfly_d  = '0;
                        q_d     = '0;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                stage_d = '0;
                bfly_d  = '0;
                q_d     = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            stage_q <= '0;
            bfly_q  <= '0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            bfly_q  <= bfly_d;
            q_q     <= q_d;
        end
    end

    // Addresses are generated from next-state counters so the outputs can be registered
    // without adding a cycle of latency.
    fft4_addr_gen #(
        .FFT_SIZE (FFT_SIZE),
        .ADDR_W   (ADDR_W),
        .STAGE_W  (STAGE_W)
    ) u_addr_gen (
        .stage     (stage_d),
        .bfly      (bfly_d),
        .q         (q_d),
        .data_addr (gen_data_addr),
        .tw_addr   (gen_tw_addr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_valid      <= 1'b0;
            op_data_addr  <= '0;
            op_tw_addr    <= '0;
            op_q          <= '0;
            op_last_bfly  <= 1'b0;
            op_last_stage <= 1'b0;
        end else if (state_d == StIssue) begin
            op_valid      <= 1'b1;
            op_data_addr  <= gen_data_addr;
            op_tw_addr    <= gen_tw_addr;
            op_q          <= q_d;
            op_last_bfly  <= (q_d == 2'd3);
            op_last_stage <= (stage_d == LAST_STAGE);
        end else begin
            op_valid      <= 1'b0;
            op_data_addr  <= '0;
            op_tw_addr    <= '0;
            op_q          <= '0;
            op_last_bfly  <= 1'b0;
            op_last_stage <= 1'b0;
        end
    end

    assign busy = (state_q == StIssue) || (state_q == StDrain);
    assign done = (state_q == StDone);

endmodule

// File: tb/tb_fft4_stage_sequencer.sv
// Scoreboard bench for fft4_stage_sequencer: reference beats from the address formulas,
// a negedge monitor comparing every accepted beat, plus backpressure/noise/reset runs.
`timescale 1ns/1ps
module tb_fft4_stage_sequencer;

    localparam int N      = 16;
    localparam int AW     = 4;
    localparam int STAGES = 2;
    localparam int BEATS  = N * STAGES;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start;
    logic          start_main = 1'b0;
    logic          start_noise = 1'b0;
    logic          busy, done, op_valid;
    logic          op_ready = 1'b1;
    logic [AW-1:0] op_data_addr, op_tw_addr;
    logic [1:0]    op_q;
    logic          op_last_bfly, op_last_stage;
    logic          stage_drained = 1'b0;

    assign start = start_main | start_noise;

    fft4_stage_sequencer #(
        .FFT_SIZE (N)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .op_valid      (op_valid),
        .op_ready      (op_ready),
        .op_data_addr  (op_data_addr),
        .op_tw_addr    (op_tw_addr),
        .op_q          (op_q),
        .op_last_bfly  (op_last_bfly),
        .op_last_stage (op_last_stage),
        .stage_drained (stage_drained)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        int tw;
        int q;
        int lb;
        int ls;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    passes = 0;
    int    beats = 0;
    int    dones = 0;
    bit    bp_en = 1'b0;
    bit    noise_en = 1'b0;
    int    drain_wait = 2;
    int    drain_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference: enumerate every beat of the transform straight from the DIF formulas.
    function automatic void push_expected();
        for (int s = 0; s < STAGES; s++) begin
            int span = N / (4 ** (s + 1));
            for (int b = 0; b < N / 4; b++) begin
                for (int q = 0; q < 4; q++) begin
                    beat_t e;
                    e.data = (b / span) * 4 * span + (b % span) + q * span;
                    e.tw   = (q * (b % span) * (4 ** s)) % N;
                    e.q    = q;
                    e.lb   = (q == 3) ? 1 : 0;
                    e.ls   = (s == STAGES - 1) ? 1 : 0;
                    exp_q.push_back(e);
                end
            end
        end
    endfunction

    // Monitor: compares accepted beats against the queue and checks stall stability.
    logic          stall = 1'b0;
    logic [AW-1:0] sv_data, sv_tw;
    logic [1:0]    sv_q;
    logic          sv_lb, sv_ls;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                check("stall_valid", int'(op_valid), 1);
                check("stall_data", int'(op_data_addr), int'(sv_data));
                check("stall_tw", int'(op_tw_addr), int'(sv_tw));
                check("stall_q", int'(op_q), int'(sv_q));
                check("stall_flags", int'({op_last_bfly, op_last_stage}), int'({sv_lb, sv_ls}));
            end
            if (done) begin
                dones++;
                check("busy_low_with_done", int'(busy), 0);
            end
            if (op_valid && op_ready) begin
                beats++;
                check("beat_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("data_addr", int'(op_data_addr), e.data);
                    check("tw_addr", int'(op_tw_addr), e.tw);
                    check("op_q", int'(op_q), e.q);
                    check("last_bfly", int'(op_last_bfly), e.lb);
                    check("last_stage", int'(op_last_stage), e.ls);
                end
            end
            stall   = op_valid && !op_ready;
            sv_data = op_data_addr;
            sv_tw   = op_tw_addr;
            sv_q    = op_q;
            sv_lb   = op_last_bfly;
            sv_ls   = op_last_stage;
        end
    end

    always @(posedge clk) begin
        #1;
        op_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Drain responder: busy with no valid beat means the sequencer is waiting to drain.
    always @(posedge clk) begin
        #1;
        if (rst_n && busy && !op_valid) begin
            drain_cnt++;
            stage_drained = (drain_cnt >= drain_wait);
        end else begin
            if (drain_cnt > 0) begin
                check("drain_cycles", drain_cnt, drain_wait);
                drain_cnt = 0;
            end
            stage_drained = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        start_noise = noise_en && (busy || done) && ($urandom_range(0, 3) == 0);
    end

    task automatic pulse_start();
        @(posedge clk);
        #1 start_main = 1'b1;
        @(posedge clk);
        #1 start_main = 1'b0;
    endtask

    task automatic run_transform(input string tag);
        int budget;
        beats = 0;
        dones = 0;
        exp_q.delete();
        push_expected();
        pulse_start();
        @(negedge clk);
        check({tag, "_first_valid"}, int'(op_valid), 1);
        check({tag, "_busy"}, int'(busy), 1);
        budget = 0;
        while (dones == 0 && budget < 3000) begin
            @(posedge clk);
            budget++;
        end
        check({tag, "_done_seen"}, int'(dones > 0), 1);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check({tag, "_beat_count"}, beats, BEATS);
        check({tag, "_done_count"}, dones, 1);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
        check({tag, "_idle_busy"}, int'(busy), 0);
        check({tag, "_idle_valid"}, int'(op_valid), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_valid"}, int'(op_valid), 0);
        check({tag, "_data"}, int'(op_data_addr), 0);
        check({tag, "_tw"}, int'(op_tw_addr), 0);
        check({tag, "_q_flags"}, int'({op_q, op_last_bfly, op_last_stage}), 0);
    endtask

    initial begin
        int budget;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_all_zero("idle");

        drain_wait = 2;
        run_transform("full");

        bp_en = 1'b1;
        drain_wait = 3;
        run_transform("backpressure");

        noise_en = 1'b1;
        run_transform("start_noise");
        noise_en = 1'b0;
        bp_en = 1'b0;

        drain_wait = 20;
        run_transform("long_drain");
        drain_wait = 2;

        // Reset in the middle of stage 0, then a clean restart.
        beats = 0;
        dones = 0;
        exp_q.delete();
        push_expected();
        pulse_start();
        budget = 0;
        while (beats < 10 && budget < 200) begin
            @(posedge clk);
            budget++;
        end
        check("midrun_reached_beat10", int'(beats >= 10), 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midrun_reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midrun_no_done", dones, 0);
        rst_n = 1'b1;
        run_transform("after_reset");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
